stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Control stage feeding the stopwatch BCD counter.
//   - Conditions two raw push-buttons.
//   - Runs the IDLE/CLEAR/RUNNING state machine and drives the one-hot state bus.
//   - Generates the one-cycle sec_pulse from a clock prescaler.
//   - Downstream counter consumes state and sec_pulse directly.
// PARAMETERS
//   TICK_DIV         100  clk cycles per sec_pulse (>=2); board build overrides to clk Hz
//   DEBOUNCE_CYCLES  16   consecutive stable samples to accept a level (DEBOUNCE_EN only)
// PORTS
//   clk          in   1  single system clock, rising edge
//   nrst         in   1  reset: synchronous, active-low
//   start_stop   in   1  raw async button, active-high; press toggles run/pause
//   clear_btn    in   1  raw async button, active-high; press zeroes the counter
//   state        out  3  one-hot: IDLE=3'b100, CLEAR=3'b010, RUNNING=3'b001
//   sec_pulse    out  1  one-cycle tick, only while RUNNING
// BEHAVIOUR
//   Reset (nrst low at a clk edge):
//     - state=IDLE, sec_pulse=0, prescaler=0
//     - sync/debounce/edge flops cleared (levels read as released)
//   Button path, per button:
//     - 2-flop synchroniser, then rising-edge detect -> press (1 clk)
//     - Held button = one press; release produces nothing
//     - Latency, no debounce: state changes 3 clk edges after the edge first sampling 1
//   FSM (registered, one transition per cycle):
//     - IDLE:    clear press -> CLEAR; else start press -> RUNNING
//       (both pressed in the same cycle: CLEAR wins)
//     - RUNNING: start press -> IDLE (pause); clear press ignored
//     - CLEAR:   unconditional -> IDLE after exactly 1 cycle; presses in CLEAR dropped
//     - Illegal encodings (not one-hot) -> IDLE next cycle
//   Prescaler (width $clog2(TICK_DIV)):
//     - RUNNING: counts 0..TICK_DIV-1, wraps to 0
//     - sec_pulse=1 (registered) the cycle after count==TICK_DIV-1 while RUNNING
//     - IDLE: count held (pause keeps the partial second); sec_pulse=0
//     - CLEAR or reset: count<=0
//     - Run->pause on the wrap cycle: wrap completes, pulse still issued,
//       then state=IDLE and pulse stops
//   Reset mid-run: next cycle IDLE, no pulse; pending presses discarded
// CONFIGURATION
//   `STOPWATCH_DEBOUNCE_EN
//     Defined:   after the synchroniser, a counter requires DEBOUNCE_CYCLES
//                consecutive equal samples before the filtered level changes;
//                glitches shorter than that are rejected;
//                latency grows by DEBOUNCE_CYCLES
//     Undefined: filtered level = synchroniser output; no counter logic synthesised
// STRUCTURE
//   stopwatch_pkg:
//     - state_t: 3-bit enum IDLE/CLEAR/RUNNING with the encodings above
//       (shared with the counter)
//     - default TICK_DIV constant
//   btn_conditioner sub-module (sync + optional debounce + edge detect):
//     - one instance per button
//     - ports: clk, nrst, btn_raw, press
//   FSM and prescaler live in stopwatch_ctrl
// TESTING (TICK_DIV=4, DEBOUNCE_CYCLES=3)
//   1. Reset held 2 cycles, buttons low
//      -> state=3'b100, sec_pulse=0 throughout; stays IDLE 20 cycles
//   2. Pulse start_stop high 1 cycle, no debounce
//      -> state=3'b001 three edges later; sec_pulse every 4th cycle, 5 pulses in 20 cycles
//   3. Run 6 cycles, press start_stop
//      -> IDLE, no pulses; press again -> first pulse arrives exactly after the
//         remaining partial count
//   4. From IDLE, raise start_stop and clear_btn in the same cycle
//      -> state 3'b010 for exactly 1 cycle, then 3'b100; prescaler 0
//   5. RUNNING, press clear_btn -> no state change; hold start_stop 50 cycles
//      -> exactly one toggle to IDLE
//   6. DEBOUNCE_EN: 2-cycle glitch on start_stop -> ignored;
//      4-cycle press -> one RUNNING transition, 3 cycles later than test 2

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and default constants for the stopwatch
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b100,
        CLEAR   = 3'b010,
        RUNNING = 3'b001
    } state_t;

    localparam int DEFAULT_TICK_DIV        = 100;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/stopwatch_ctrl_btn.sv
// rtl/stopwatch_ctrl_btn.sv - button conditioner: synchroniser, optional debounce, press edge
// Debounce filter present only when STOPWATCH_DEBOUNCE_EN is defined.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_raw,
    output logic press
);

    logic r_sync1;
    logic r_sync2;
    logic r_level_d;
    logic r_press;
    logic w_level;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] r_db_cnt;
    logic          r_filt;

    // Counter tracks consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_db_cnt <= '0;
            r_filt   <= 1'b0;
        end else if (r_sync2 != r_filt) begin
            if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_filt   <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_level = r_filt;
`else
    logic w_unused_debounce;
    assign w_unused_debounce = (DEBOUNCE_CYCLES > 0);
    assign w_level           = r_sync2;
`endif

    // Registered rising edge: a held button yields exactly one press.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= w_level;
            r_press   <= w_level & ~r_level_d;
        end
    end

    assign press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control: button handling, IDLE/CLEAR/RUNNING FSM, second prescaler
// Button debounce enabled by defining STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = DEFAULT_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start_stop,
    input  logic       clear_btn,
    output logic [2:0] state,
    output logic       sec_pulse
);

    localparam int             PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

    logic          w_start_press;
    logic          w_clear_press;
    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_presc;
    logic          r_pulse;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
        .clk     (clk),
        .nrst    (nrst),
        .btn_raw (start_stop),
        .press   (w_start_press)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_btn (
        .clk     (clk),
        .nrst    (nrst),
        .btn_raw (clear_btn),
        .press   (w_clear_press)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE: begin
                if (w_clear_press) begin
                    w_next = CLEAR;
                end else if (w_start_press) begin
                    w_next = RUNNING;
                end else begin
                    w_next = IDLE;
                end
            end
            RUNNING: w_next = w_start_press ? IDLE : RUNNING;
            CLEAR:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Pausing holds the partial count so resuming finishes the current second.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_presc <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= (r_state == RUNNING) && (r_presc == LAST);
            case (r_state)
                RUNNING: r_presc <= (r_presc == LAST) ? '0 : r_presc + 1'b1;
                IDLE:    r_presc <= r_presc;
                default: r_presc <= '0;
            endcase
        end
    end

    assign state     = r_state;
    assign sec_pulse = r_pulse;

endmodule
